// File: rtl/multi_timer_pkg.sv
// Shared encodings for the multi-channel interval timer: FSM states,
// register word offsets and CTRL bit positions.
package multi_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_CNT    = 2'd2,
      ST_EXPIRE = 2'd3
   } state_e;

   // Word offsets inside a 16-byte channel window
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;

   // Word offsets relative to the global block that follows the channels
   localparam logic [1:0] GLB_STATUS   = 2'd0;
   localparam logic [1:0] GLB_PRESCALE = 2'd1;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_IRQ  = 3;
   localparam int CTRL_PEND = 4;

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: CTRL bits, PRESET, COUNT, sticky pending flag and the
// IDLE/LOAD/CNT/EXPIRE sequencer. Bus writes never stall the counting.
module multi_timer_channel
   import multi_timer_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick_i,
   input  logic                 ctrl_we_i,
   input  logic                 ctrl_en_i,
   input  logic                 ctrl_mode_i,
   input  logic                 ctrl_irq_i,
   input  logic                 preset_we_i,
   input  logic [CNT_WIDTH-1:0] preset_i,
   input  logic                 clr_i,
   output logic                 enable_o,
   output logic                 mode_o,
   output logic                 allow_irq_o,
   output logic                 pending_o,
   output logic [CNT_WIDTH-1:0] count_o,
   output logic [CNT_WIDTH-1:0] preset_o
);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH-1:0] preset_q, preset_d;
   logic                 enable_q, enable_d;
   logic                 mode_q, mode_d;
   logic                 allow_q, allow_d;
   logic                 pending_q, pending_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         preset_q  <= '0;
         enable_q  <= 1'b0;
         mode_q    <= 1'b0;
         allow_q   <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         preset_q  <= preset_d;
         enable_q  <= enable_d;
         mode_q    <= mode_d;
         allow_q   <= allow_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      preset_d  = preset_we_i ? preset_i : preset_q;
      enable_d  = ctrl_we_i ? ctrl_en_i : enable_q;
      mode_d    = ctrl_we_i ? ctrl_mode_i : mode_q;
      allow_d   = ctrl_we_i ? ctrl_irq_i : allow_q;
      // A new expiry below overrides a same-cycle clear
      pending_d = clr_i ? 1'b0 : pending_q;

      case (state_q)
         ST_IDLE: begin
            if (enable_q) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!enable_q) begin
               state_d = ST_IDLE;
            end else if (tick_i) begin
               if (count_q > CNT_WIDTH'(1)) begin
                  count_d = count_q - CNT_WIDTH'(1);
               end else begin
                  count_d   = '0;
                  pending_d = 1'b1;
                  state_d   = ST_EXPIRE;
               end
            end
         end
         ST_EXPIRE: begin
            if (mode_q) begin
               count_d = preset_q;
               state_d = ST_CNT;
            end else begin
               enable_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign enable_o    = enable_q;
   assign mode_o      = mode_q;
   assign allow_irq_o = allow_q;
   assign pending_o   = pending_q;
   assign count_o     = count_q;
   assign preset_o    = preset_q;

endmodule

// File: rtl/multi_timer.sv
// Memory-mapped multi-channel interval timer: address decode, shared
// prescaler, read mux and the combined interrupt line.
module multi_timer
   import multi_timer_pkg::*;
#(
   parameter logic [31:0] BASE      = 32'h0000_7f00,
   parameter int          CHANNELS  = 2,
   parameter int          CNT_WIDTH = 32,
   parameter int          PRE_WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         addr,
   input  logic                write_enable,
   input  logic [31:0]         write_data,
   output logic [31:0]         read_result,
   output logic                irq,
   output logic [CHANNELS-1:0] irq_vec
);

   localparam logic [29:0] G_WORD = 30'(4 * CHANNELS);

   logic [31:0] off;
   logic [29:0] word;
   logic        unused_off_lsbs;
   logic        in_chan, status_hit, prescale_hit;

   // Byte offsets below BASE wrap to huge values and fall out as unmapped
   assign off             = addr - BASE;
   assign word            = off[31:2];
   assign unused_off_lsbs = ^off[1:0];
   assign in_chan         = (word < G_WORD);
   assign status_hit      = (word == G_WORD + 30'(GLB_STATUS));
   assign prescale_hit    = (word == G_WORD + 30'(GLB_PRESCALE));

   logic [PRE_WIDTH-1:0] prescale_q, prescale_d, pc_q, pc_d;
   logic                 tick;

   assign tick = (pc_q == prescale_q);

   always_comb begin
      prescale_d = prescale_q;
      pc_d       = tick ? '0 : pc_q + PRE_WIDTH'(1);
      if (write_enable && prescale_hit) begin
         prescale_d = write_data[PRE_WIDTH-1:0];
         pc_d       = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prescale_q <= '0;
         pc_q       <= '0;
      end else begin
         prescale_q <= prescale_d;
         pc_q       <= pc_d;
      end
   end

   logic [CHANNELS-1:0]  en, mode, allow, pending;
   logic [CHANNELS-1:0]  ctrl_we, preset_we, clr;
   logic [CNT_WIDTH-1:0] count  [CHANNELS];
   logic [CNT_WIDTH-1:0] preset [CHANNELS];

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic sel;
      assign sel          = in_chan && (word[29:2] == 28'(i));
      assign ctrl_we[i]   = write_enable && sel && (word[1:0] == REG_CTRL);
      assign preset_we[i] = write_enable && sel && (word[1:0] == REG_PRESET);
      assign clr[i]       = write_enable && status_hit && write_data[i];

      multi_timer_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
         .clk         (clk),
         .rst         (rst),
         .tick_i      (tick),
         .ctrl_we_i   (ctrl_we[i]),
         .ctrl_en_i   (write_data[CTRL_EN]),
         .ctrl_mode_i (write_data[CTRL_MODE]),
         .ctrl_irq_i  (write_data[CTRL_IRQ]),
         .preset_we_i (preset_we[i]),
         .preset_i    (write_data[CNT_WIDTH-1:0]),
         .clr_i       (clr[i]),
         .enable_o    (en[i]),
         .mode_o      (mode[i]),
         .allow_irq_o (allow[i]),
         .pending_o   (pending[i]),
         .count_o     (count[i]),
         .preset_o    (preset[i])
      );
   end

   function automatic logic [31:0] ctrl_word(input logic e, input logic m,
                                             input logic a, input logic p);
      logic [31:0] w;
      w            = '0;
      w[CTRL_EN]   = e;
      w[CTRL_MODE] = m;
      w[CTRL_IRQ]  = a;
      w[CTRL_PEND] = p;
      return w;
   endfunction

   always_comb begin
      read_result = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (in_chan && (word[29:2] == 28'(i))) begin
            case (word[1:0])
               REG_CTRL:   read_result = ctrl_word(en[i], mode[i], allow[i], pending[i]);
               REG_PRESET: read_result = 32'(preset[i]);
               REG_COUNT:  read_result = 32'(count[i]);
               default:    read_result = '0;
            endcase
         end
      end
      if (status_hit)   read_result = 32'(pending);
      if (prescale_hit) read_result = 32'(prescale_q);
   end

   assign irq_vec = pending & allow;
   assign irq     = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: stimulus pushes expected reads and irq
// edges; a monitor pops and compares them against a tick-schedule model.
module tb_multi_timer;

   localparam logic [31:0] BASE = 32'h0000_7f00;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wd = 32'h0;
   logic [31:0] rd;
   logic        irq;
   logic [1:0]  irq_vec;

   multi_timer #(.BASE(BASE), .CHANNELS(2), .CNT_WIDTH(32), .PRE_WIDTH(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .addr         (addr),
      .write_enable (we),
      .write_data   (wd),
      .read_result  (rd),
      .irq          (irq),
      .irq_vec      (irq_vec)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { string name; logic [31:0] val; } rd_exp_t;
   typedef struct { int cyc; logic lvl; logic [1:0] vec; } irq_exp_t;
   rd_exp_t  rd_q[$];
   irq_exp_t irq_q[$];

   int   n_checks = 0;
   int   n_fail = 0;
   logic rd_vld = 1'b0;
   logic mon_on = 1'b0;
   logic irq_prev = 1'b0;
   logic model_irq = 1'b0;
   int   e_last = 0;

   // Model of the prescaler: ticks fall every PRE+1 edges after its restart edge
   int pre_p = 0;
   int pre_s = 0;

   function automatic logic [31:0] a_ch(input int ch, input int r);
      return BASE + 32'(16 * ch + 4 * r);
   endfunction

   localparam logic [31:0] A_STATUS = BASE + 32'd32;
   localparam logic [31:0] A_PRE    = BASE + 32'd36;
   localparam logic [31:0] A_UNM    = BASE + 32'd40;

   function automatic bit tick_at(input int t);
      return (t > pre_s) && (((t - pre_s) % (pre_p + 1)) == 0);
   endfunction

   function automatic int nth_tick_after(input int t, input int n);
      int k = 0;
      int x = t;
      int m = (n < 1) ? 1 : n;
      while (k < m) begin
         x++;
         if (tick_at(x)) k++;
      end
      return x;
   endfunction

   // Count seen after edge c for a one-shot enabled at edge e0 with preset n
   function automatic logic [31:0] count_at(input int c, input int e0, input int n);
      int k = 0;
      if (c < e0 + 2) return 32'd0;
      for (int t = e0 + 3; t <= c; t++) if (tick_at(t)) k++;
      return (n > k) ? 32'(n - k) : 32'd0;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always begin
      @(negedge clk);
      #2;
      if (rd_vld) begin
         if (rd_q.size() == 0) begin
            check("read_without_expectation", 32'd1, 32'd0);
         end else begin
            rd_exp_t e;
            e = rd_q.pop_front();
            check(e.name, rd, e.val);
         end
      end
      if (mon_on && (irq !== irq_prev)) begin
         if (irq_q.size() == 0) begin
            check("irq_unexpected_edge", 32'(irq), 32'(irq_prev));
         end else begin
            irq_exp_t x;
            x = irq_q.pop_front();
            check("irq_edge_cycle", 32'(cyc), 32'(x.cyc));
            check("irq_edge_level", 32'(irq), 32'(x.lvl));
            check("irq_vec_at_edge", 32'(irq_vec), 32'(x.vec));
         end
      end
      irq_prev = irq;
   end

   // All stimulus tasks start and end on a falling edge
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      wd   = d;
      we   = 1'b1;
      @(negedge clk);
      we     = 1'b0;
      e_last = cyc;
   endtask

   task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
      addr   = a;
      rd_vld = 1'b1;
      rd_q.push_back('{nm, exp});
      @(negedge clk);
      rd_vld = 1'b0;
   endtask

   task automatic exp_irq(input int c, input logic lvl, input logic [1:0] vec);
      irq_q.push_back('{c, lvl, vec});
      model_irq = lvl;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      we  = 1'b0;
      @(negedge clk);
      rst   = 1'b0;
      pre_s = cyc;
      pre_p = 0;
      if (model_irq) exp_irq(cyc, 1'b0, 2'b00);
   endtask

   task automatic run_oneshot(input int ch, input int n, input int p, input bit al);
      int e0, x;
      wr(A_PRE, 32'(p));
      pre_p = p;
      pre_s = e_last;
      wr(a_ch(ch, 1), 32'(n));
      wr(a_ch(ch, 0), al ? 32'h9 : 32'h1);
      e0 = e_last;
      x  = nth_tick_after(e0 + 2, n);
      if (al) exp_irq(x, 1'b1, 2'(1 << ch));
      for (int c = e0; c <= x + 1; c++) rd_chk(a_ch(ch, 2), count_at(c, e0, n), "oneshot_count");
      rd_chk(a_ch(ch, 0), al ? 32'h18 : 32'h10, "oneshot_ctrl_done");
      rd_chk(A_STATUS, 32'(1 << ch), "oneshot_status");
      rd_chk(a_ch(ch, 1), 32'(n), "oneshot_preset");
      rd_chk(a_ch(1 - ch, 0), 32'h0, "oneshot_other_ctrl");
      rd_chk(A_PRE, 32'(p), "oneshot_prescale");
      if (al) exp_irq(cyc + 1, 1'b0, 2'b00);
      wr(A_STATUS, 32'(1 << ch));
      rd_chk(A_STATUS, 32'h0, "oneshot_status_cleared");
      do_reset();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, e1, x1, x2, x3, xa, xb;
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      pre_s  = cyc;
      mon_on = 1'b1;

      rd_chk(a_ch(0, 0), 32'h0, "reset_ctrl0");
      rd_chk(a_ch(0, 1), 32'h0, "reset_preset0");
      rd_chk(a_ch(1, 2), 32'h0, "reset_count1");
      rd_chk(A_STATUS, 32'h0, "reset_status");
      rd_chk(A_PRE, 32'h0, "reset_prescale");

      // One-shot, no prescale, then prescaled run
      run_oneshot(0, 3, 0, 1'b1);
      run_oneshot(0, 2, 3, 1'b1);

      // Periodic ch1, PRESET=2
      wr(a_ch(1, 1), 32'd2);
      wr(a_ch(1, 0), 32'hB);
      e0 = e_last;
      x1 = nth_tick_after(e0 + 2, 2);
      exp_irq(x1, 1'b1, 2'b10);
      wait_until(x1);
      exp_irq(x1 + 1, 1'b0, 2'b00);
      wr(A_STATUS, 32'h2);
      rd_chk(a_ch(1, 2), 32'd2, "periodic_reload");
      rd_chk(A_STATUS, 32'h0, "periodic_cleared");
      x2 = nth_tick_after(x1 + 1, 2);
      exp_irq(x2, 1'b1, 2'b10);
      wait_until(x2);
      rd_chk(A_STATUS, 32'h2, "periodic_reassert");
      exp_irq(cyc + 1, 1'b0, 2'b00);
      wr(A_STATUS, 32'h2);
      x3 = nth_tick_after(x2 + 1, 2);
      exp_irq(x3, 1'b1, 2'b10);
      wait_until(x3 + 1);
      rd_chk(a_ch(1, 0), 32'h1B, "periodic_ctrl");
      do_reset();

      // Same-edge clear and expiry: set wins on ch0, ch1 clears
      wr(a_ch(1, 1), 32'd1);
      wr(a_ch(1, 0), 32'h9);
      e1 = e_last;
      xb = nth_tick_after(e1 + 2, 1);
      exp_irq(xb, 1'b1, 2'b10);
      wr(a_ch(0, 1), 32'd3);
      wr(a_ch(0, 0), 32'h9);
      e0 = e_last;
      xa = nth_tick_after(e0 + 2, 3);
      wait_until(xa - 1);
      wr(A_STATUS, 32'h3);
      rd_chk(A_STATUS, 32'h1, "w1c_set_wins");
      rd_chk(a_ch(1, 0), 32'h8, "w1c_ch1_cleared");
      rd_chk(a_ch(0, 0), 32'h18, "w1c_ch0_ctrl");
      exp_irq(cyc + 1, 1'b0, 2'b00);
      wr(a_ch(0, 0), 32'h0);
      rd_chk(a_ch(0, 0), 32'h10, "mask_keeps_pending");
      wr(A_STATUS, 32'h1);
      rd_chk(A_STATUS, 32'h0, "mask_then_clear");
      do_reset();

      // PRESET rewrite mid-count, then reset mid-count
      wr(a_ch(0, 1), 32'd5);
      wr(a_ch(0, 0), 32'hB);
      e0 = e_last;
      x1 = nth_tick_after(e0 + 2, 5);
      exp_irq(x1, 1'b1, 2'b01);
      wait_until(e0 + 3);
      wr(a_ch(0, 1), 32'd9);
      rd_chk(a_ch(0, 2), 32'd3, "preset_wr_count_mid");
      rd_chk(a_ch(0, 1) | 32'h2, 32'd9, "preset_new_value");
      wait_until(x1);
      rd_chk(a_ch(0, 2), 32'd0, "preset_wr_expiry");
      rd_chk(a_ch(0, 2), 32'd9, "preset_wr_reload");
      rd_chk(a_ch(0, 2), 32'd8, "preset_wr_next");
      do_reset();
      rd_chk(a_ch(0, 0), 32'h0, "rst_ctrl0");
      rd_chk(a_ch(0, 1), 32'h0, "rst_preset0");
      rd_chk(a_ch(0, 2), 32'h0, "rst_count0");
      rd_chk(A_STATUS, 32'h0, "rst_status");
      repeat (12) @(negedge clk);
      rd_chk(a_ch(0, 2), 32'h0, "rst_count_stays");

      // Unmapped and read-only accesses
      wr(A_UNM, 32'hFFFF_FFFF);
      rd_chk(A_UNM, 32'h0, "unmapped_read");
      rd_chk(BASE - 32'd4, 32'h0, "below_base_read");
      rd_chk(a_ch(0, 3), 32'h0, "chan_hole_read");
      wr(a_ch(0, 2), 32'h55);
      rd_chk(a_ch(0, 2), 32'h0, "count_write_ignored");
      rd_chk(A_STATUS, 32'h0, "status_after_unmapped");
      run_oneshot(1, 0, 0, 1'b1);

      for (int it = 0; it < 14; it++) begin
         run_oneshot(int'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(rd_q.size() + irq_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
